sht40_meas_scheduler: RTL and testbench
=======================================

// Module: sht40_meas_scheduler
// PURPOSE
//  Sequences the I2C master and SHT40 reader through periodic temperature/RH measurements.
//  Each cycle is: write command 0xFD to address 0x44, wait for conversion, read the 6-byte result.
//  Drives the master's Processor_Ready / i2c_writes / address / command inputs from a state machine.
//  Replaces the static initial-block stimulus in the top level. Adds retry, timeout and status reporting.
// PARAMETERS
//  SHT_ADDR        7'h44        peripheral address driven on peripheral_address
//  SHT_CMD         8'hFD        measurement command (high precision)
//  MEAS_WAIT_CYC   1_000_000    conversion wait, clk cycles (10 ms @ 100 MHz); must be >= 1
//  PERIOD_CYC      100_000_000  clk cycles between measurement starts when enable=1
//  XFER_TIMEOUT    200_000      max clk cycles allowed in any *_REQ or *_WAIT state
//  RETRY_MAX       3            retries per measurement after the first attempt
// PORTS
//  clk                  in   1  system clock
//  rst                  in   1  asynchronous reset, active-high
//  enable               in   1  level; 1 = periodic measurements
//  single_shot          in   1  one-cycle pulse; requests one measurement
//  master_idle          in   1  1 = I2C master idle (decoded from Master_State_Out)
//  temp_ready           in   1  Temp_Ready_Out from the SHT40 reader
//  rh_ready             in   1  RH_Ready_Out from the SHT40 reader
//  crc_error            in   1  CRC_Error_Out from the master/reader
//  processor_ready      out  1  to master Processor_Ready
//  i2c_writes           out  1  to master i2c_writes; 1 = write phase, 0 = read phase
//  peripheral_address   out  7  to master; constant SHT_ADDR
//  command_data_frames  out  8  to master; constant SHT_CMD
//  busy                 out  1  1 in every state except IDLE
//  meas_valid           out  1  one-cycle pulse: read finished, both ready flags seen, no CRC error
//  meas_error           out  1  one-cycle pulse: retries exhausted
//  error_count          out  8  saturating count of failed attempts
// BEHAVIOUR
//  Reset values: processor_ready=0, i2c_writes=1, busy=0, meas_valid=0, meas_error=0,
//   error_count=0, retry counter=0, period counter=0, pending=0, state=IDLE.
//   peripheral_address and command_data_frames are always SHT_ADDR / SHT_CMD.
//  States:
//   IDLE: go to WR_REQ on single_shot, pending, or enable with period expired.
//    From reset, enable=1 starts a measurement on the next cycle.
//   WR_REQ: i2c_writes=1, processor_ready=1. Go to WR_WAIT on the first cycle master_idle=0;
//    processor_ready drops in the same edge.
//   WR_WAIT: wait for master_idle=1, then go to MEAS_WAIT. Clear the sticky flags there.
//   MEAS_WAIT: count MEAS_WAIT_CYC cycles, then go to RD_REQ.
//   RD_REQ: same as WR_REQ with i2c_writes=0. Go to RD_WAIT.
//   RD_WAIT: OR temp_ready, rh_ready and crc_error into sticky flags. On master_idle=1,
//    evaluate the flags (including the current cycle's inputs) and go to DONE.
//   DONE (1 cycle): on success, pulse meas_valid, clear retries, go to IDLE.
//    On failure, increment error_count (saturates at 255).
//     - If retries < RETRY_MAX: retries+1, go to WR_REQ.
//     - Otherwise: pulse meas_error, clear retries, go to IDLE.
//  Timeout: a counter restarts on each entry to WR_REQ, WR_WAIT, RD_REQ and RD_WAIT.
//   Reaching XFER_TIMEOUT counts as a failure: deassert processor_ready, go to DONE.
//  Period: the period counter restarts on each WR_REQ entry taken from IDLE (retries do not
//   restart it) and saturates at PERIOD_CYC-1. Expired = counter at PERIOD_CYC-1.
//   If a measurement takes longer than PERIOD_CYC, the next one starts right after IDLE is entered.
//  single_shot while busy: sets pending (one deep; extra pulses are dropped).
//   Pending clears when IDLE leaves for WR_REQ.
//  single_shot with enable=1 in IDLE: starts one measurement and restarts the period.
//  enable dropping mid-measurement: the current measurement, including retries, completes.
//  Reset mid-transfer: processor_ready goes to 0 asynchronously. The master recovers independently.
//  Latency: WR_REQ entry -> meas_valid is at least MEAS_WAIT_CYC + both transfers + 4 cycles.
// TESTING (bench: MEAS_WAIT_CYC=20, PERIOD_CYC=200, XFER_TIMEOUT=100; behavioural master model)
//  - single_shot, master ok -> WR_REQ(writes=1), read(writes=0) 20 cycles after write idle;
//    meas_valid pulses exactly once; busy returns to 0.
//  - enable=1 held for 650 cycles -> 4 measurement starts, at cycles 1, 201, 401 and 601 relative to reset release.
//  - crc_error during every read -> 4 attempts, error_count=4, one meas_error pulse, no meas_valid.
//  - master_idle stuck at 1 -> REQ times out after 100 cycles; 3 retries;
//    meas_error after 4 timeouts; processor_ready=0 after.
//  - single_shot x3 while busy -> exactly one extra measurement follows (pending is one deep).
//  - rst asserted mid-RD_WAIT -> every output equals its reset value immediately;
//    error_count=0; normal run after release.

Source files
------------

// File: rtl/sht40_meas_scheduler.sv
// sht40_meas_scheduler
//   Sequences the I2C master and SHT40 reader through periodic temperature/RH
//   measurements: write command SHT_CMD to SHT_ADDR, wait for conversion, then
//   read the 6-byte result. Failed attempts (CRC error, missing ready flag or
//   transfer timeout) are retried up to RETRY_MAX times.
// Ports
//   clk, rst             system clock, asynchronous active-high reset
//   enable               level, 1 = periodic measurements every PERIOD_CYC
//   single_shot          one-cycle pulse requesting one measurement
//   master_idle          1 = I2C master idle
//   temp_ready/rh_ready  ready flags from the SHT40 reader
//   crc_error            CRC error flag from the master/reader
//   processor_ready      request strobe to the master (held until it goes busy)
//   i2c_writes           1 = write phase, 0 = read phase
//   peripheral_address   constant SHT_ADDR
//   command_data_frames  constant SHT_CMD
//   busy                 1 whenever not IDLE
//   meas_valid           one-cycle pulse on a successful measurement
//   meas_error           one-cycle pulse when retries are exhausted
//   error_count          saturating count of failed attempts
module sht40_meas_scheduler #(
  parameter logic [6:0]  SHT_ADDR      = 7'h44,
  parameter logic [7:0]  SHT_CMD       = 8'hFD,
  parameter int unsigned MEAS_WAIT_CYC = 1_000_000,
  parameter int unsigned PERIOD_CYC    = 100_000_000,
  parameter int unsigned XFER_TIMEOUT  = 200_000,
  parameter int unsigned RETRY_MAX     = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable,
  input  logic       single_shot,
  input  logic       master_idle,
  input  logic       temp_ready,
  input  logic       rh_ready,
  input  logic       crc_error,
  output logic       processor_ready,
  output logic       i2c_writes,
  output logic [6:0] peripheral_address,
  output logic [7:0] command_data_frames,
  output logic       busy,
  output logic       meas_valid,
  output logic       meas_error,
  output logic [7:0] error_count
);

  localparam int unsigned TMR_MAX = (MEAS_WAIT_CYC > XFER_TIMEOUT) ? MEAS_WAIT_CYC : XFER_TIMEOUT;
  localparam int unsigned TW      = $clog2(TMR_MAX + 1);
  localparam int unsigned PW      = $clog2(PERIOD_CYC + 1);
  localparam int unsigned RW      = $clog2(RETRY_MAX + 2);

  localparam logic [TW-1:0] MEAS_LAST   = TW'(MEAS_WAIT_CYC - 1);
  localparam logic [TW-1:0] XFER_LAST   = TW'(XFER_TIMEOUT - 1);
  localparam logic [PW-1:0] PERIOD_LAST = PW'(PERIOD_CYC - 1);
  localparam logic [RW-1:0] RETRY_LAST  = RW'(RETRY_MAX);

  typedef enum logic [2:0] {
    IDLE, WR_REQ, WR_WAIT, MEAS_WAIT, RD_REQ, RD_WAIT, DONE
  } state_t;

  state_t        state, state_d;
  logic [TW-1:0] tmr;
  logic [PW-1:0] period_cnt;
  logic [RW-1:0] retries, retries_d;
  logic [7:0]    err_cnt, err_cnt_d;
  logic          pending, pending_d;
  logic          ran_once;
  logic          temp_f, rh_f, crc_f;
  logic          temp_d, rh_d, crc_d;
  logic          ok, ok_d;
  logic          period_restart;
  logic          xfer_to;

  assign peripheral_address  = SHT_ADDR;
  assign command_data_frames = SHT_CMD;
  assign error_count         = err_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      tmr        <= '0;
      period_cnt <= '0;
      retries    <= '0;
      err_cnt    <= '0;
      pending    <= 1'b0;
      ran_once   <= 1'b0;
      temp_f     <= 1'b0;
      rh_f       <= 1'b0;
      crc_f      <= 1'b0;
      ok         <= 1'b0;
    end else begin
      state   <= state_d;
      retries <= retries_d;
      err_cnt <= err_cnt_d;
      pending <= pending_d;
      temp_f  <= temp_d;
      rh_f    <= rh_d;
      crc_f   <= crc_d;
      ok      <= ok_d;
      // One timer serves both the conversion wait and the transfer timeout:
      // it restarts on every state change, so each state sees it from zero.
      if (state_d != state)
        tmr <= '0;
      else if (tmr != '1)
        tmr <= tmr + TW'(1);
      if (period_restart) begin
        period_cnt <= '0;
        ran_once   <= 1'b1;
      end else if (period_cnt != PERIOD_LAST) begin
        period_cnt <= period_cnt + PW'(1);
      end
    end
  end

  always_comb begin
    state_d         = state;
    retries_d       = retries;
    err_cnt_d       = err_cnt;
    pending_d       = pending;
    temp_d          = temp_f;
    rh_d            = rh_f;
    crc_d           = crc_f;
    ok_d            = ok;
    period_restart  = 1'b0;
    processor_ready = 1'b0;
    i2c_writes      = 1'b1;
    busy            = (state != IDLE);
    meas_valid      = 1'b0;
    meas_error      = 1'b0;
    xfer_to         = (tmr == XFER_LAST);

    if (single_shot && (state != IDLE))
      pending_d = 1'b1;

    case (state)
      IDLE: begin
        // The first enable-driven start after reset does not wait a period.
        if (single_shot || pending ||
            (enable && (!ran_once || (period_cnt == PERIOD_LAST)))) begin
          state_d        = WR_REQ;
          pending_d      = 1'b0;
          period_restart = 1'b1;
        end
      end
      WR_REQ: begin
        processor_ready = 1'b1;
        if (!master_idle) begin
          state_d = WR_WAIT;
        end else if (xfer_to) begin
          state_d = DONE;
          ok_d    = 1'b0;
        end
      end
      WR_WAIT: begin
        if (master_idle) begin
          state_d = MEAS_WAIT;
          temp_d  = 1'b0;
          rh_d    = 1'b0;
          crc_d   = 1'b0;
        end else if (xfer_to) begin
          state_d = DONE;
          ok_d    = 1'b0;
        end
      end
      MEAS_WAIT: begin
        if (tmr == MEAS_LAST)
          state_d = RD_REQ;
      end
      RD_REQ: begin
        processor_ready = 1'b1;
        i2c_writes      = 1'b0;
        if (!master_idle) begin
          state_d = RD_WAIT;
        end else if (xfer_to) begin
          state_d = DONE;
          ok_d    = 1'b0;
        end
      end
      RD_WAIT: begin
        i2c_writes = 1'b0;
        temp_d     = temp_f | temp_ready;
        rh_d       = rh_f | rh_ready;
        crc_d      = crc_f | crc_error;
        if (master_idle) begin
          state_d = DONE;
          ok_d    = temp_d & rh_d & ~crc_d;
        end else if (xfer_to) begin
          state_d = DONE;
          ok_d    = 1'b0;
        end
      end
      DONE: begin
        if (ok) begin
          meas_valid = 1'b1;
          retries_d  = '0;
          state_d    = IDLE;
        end else begin
          if (err_cnt != 8'hFF)
            err_cnt_d = err_cnt + 8'd1;
          if (retries < RETRY_LAST) begin
            retries_d = retries + RW'(1);
            state_d   = WR_REQ;
          end else begin
            meas_error = 1'b1;
            retries_d  = '0;
            state_d    = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_sht40_meas_scheduler.sv
// tb_sht40_meas_scheduler
//   Bench for sht40_meas_scheduler with a behavioural I2C master / SHT40 model.
//   The master accepts a request when idle, stays busy a random 3..8 cycles,
//   and on reads pulses temp_ready one cycle before the end and rh_ready on the
//   cycle it returns idle. Modes: OK, CRC (crc_error on every read), STUCK
//   (master_idle held at 1, never accepts).
module tb_sht40_meas_scheduler;

  localparam int unsigned MW = 20;
  localparam int unsigned PC = 200;
  localparam int unsigned XT = 100;
  localparam int unsigned RM = 3;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       enable = 1'b0;
  logic       single_shot = 1'b0;
  logic       master_idle;
  logic       temp_ready;
  logic       rh_ready;
  logic       crc_error;
  logic       processor_ready;
  logic       i2c_writes;
  logic [6:0] peripheral_address;
  logic [7:0] command_data_frames;
  logic       busy;
  logic       meas_valid;
  logic       meas_error;
  logic [7:0] error_count;

  sht40_meas_scheduler #(
    .SHT_ADDR     (7'h44),
    .SHT_CMD      (8'hFD),
    .MEAS_WAIT_CYC(MW),
    .PERIOD_CYC   (PC),
    .XFER_TIMEOUT (XT),
    .RETRY_MAX    (RM)
  ) dut (
    .clk                (clk),
    .rst                (rst),
    .enable             (enable),
    .single_shot        (single_shot),
    .master_idle        (master_idle),
    .temp_ready         (temp_ready),
    .rh_ready           (rh_ready),
    .crc_error          (crc_error),
    .processor_ready    (processor_ready),
    .i2c_writes         (i2c_writes),
    .peripheral_address (peripheral_address),
    .command_data_frames(command_data_frames),
    .busy               (busy),
    .meas_valid         (meas_valid),
    .meas_error         (meas_error),
    .error_count        (error_count)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  typedef enum int {M_OK, M_CRC, M_STUCK} mode_t;
  mode_t mode = M_OK;

  int   ncyc = 0;
  int   busy_left = 0;
  logic rd_xfer = 1'b0;
  logic prev_pr = 1'b0;
  int   rise_t = 0;
  int   wr_t[$], rd_t[$], wr_done_t[$], rd_done_t[$], req_len[$], valid_t[$], err_t[$];

  // Event log plus master model, both on the falling edge so DUT inputs
  // change half a cycle away from the sampling edge.
  always @(negedge clk) begin
    ncyc++;
    if (meas_valid) valid_t.push_back(ncyc);
    if (meas_error) err_t.push_back(ncyc);
    if (processor_ready && !prev_pr) begin
      rise_t = ncyc;
      if (i2c_writes) wr_t.push_back(ncyc);
      else            rd_t.push_back(ncyc);
    end
    if (!processor_ready && prev_pr) req_len.push_back(ncyc - rise_t);
    prev_pr = processor_ready;

    temp_ready = 1'b0;
    rh_ready   = 1'b0;
    crc_error  = 1'b0;
    if (rst) begin
      master_idle = 1'b1;
      busy_left   = 0;
    end else if (mode == M_STUCK) begin
      master_idle = 1'b1;
    end else if (busy_left > 0) begin
      busy_left--;
      if (busy_left == 1 && rd_xfer) begin
        temp_ready = 1'b1;
        crc_error  = (mode == M_CRC);
      end
      if (busy_left == 0) begin
        master_idle = 1'b1;
        if (rd_xfer) begin
          rh_ready = 1'b1;
          rd_done_t.push_back(ncyc);
        end else begin
          wr_done_t.push_back(ncyc);
        end
      end
    end else if (processor_ready && master_idle) begin
      master_idle = 1'b0;
      rd_xfer     = !i2c_writes;
      busy_left   = $urandom_range(3, 8);
    end
  end

  task automatic clear_log();
    wr_t.delete(); rd_t.delete(); wr_done_t.delete(); rd_done_t.delete();
    req_len.delete(); valid_t.delete(); err_t.delete();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic pulse_single();
    @(negedge clk); #1 single_shot = 1'b1;
    @(negedge clk); #1 single_shot = 1'b0;
  endtask

  // Waits until busy has been low for 5 consecutive cycles.
  task automatic wait_quiet(input int bound, output bit ok);
    int q;
    q  = 0;
    ok = 1'b0;
    for (int i = 0; i < bound; i++) begin
      @(negedge clk); #1;
      if (!busy) q++; else q = 0;
      if (q >= 5) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    mode = M_OK;
    clear_log();
    do_reset();
    @(negedge clk); #1;
    n_checks++; if (processor_ready !== 1'b0) begin n_fail++; $display("FAIL reset_pr got=%b exp=0", processor_ready); end
    n_checks++; if (i2c_writes !== 1'b1) begin n_fail++; $display("FAIL reset_writes got=%b exp=1", i2c_writes); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got=%b exp=0", busy); end
    n_checks++; if (meas_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got=%b exp=0", meas_valid); end
    n_checks++; if (meas_error !== 1'b0) begin n_fail++; $display("FAIL reset_error got=%b exp=0", meas_error); end
    n_checks++; if (error_count !== 8'd0) begin n_fail++; $display("FAIL reset_errcnt got=%0d exp=0", error_count); end
    n_checks++; if (peripheral_address !== 7'h44) begin n_fail++; $display("FAIL addr got=%h exp=44", peripheral_address); end
    n_checks++; if (command_data_frames !== 8'hFD) begin n_fail++; $display("FAIL cmd got=%h exp=fd", command_data_frames); end
  endtask

  task automatic test_single_shot();
    bit ok;
    mode = M_OK;
    for (int k = 0; k < 3; k++) begin
      clear_log();
      pulse_single();
      wait_quiet(500, ok);
      n_checks++; if (!ok) begin n_fail++; $display("FAIL ss_quiet[%0d] busy never settled", k); end
      n_checks++; if (wr_t.size() !== 1) begin n_fail++; $display("FAIL ss_wr_count[%0d] got=%0d exp=1", k, wr_t.size()); end
      n_checks++; if (rd_t.size() !== 1) begin n_fail++; $display("FAIL ss_rd_count[%0d] got=%0d exp=1", k, rd_t.size()); end
      n_checks++; if (valid_t.size() !== 1) begin n_fail++; $display("FAIL ss_valid_count[%0d] got=%0d exp=1", k, valid_t.size()); end
      n_checks++; if (err_t.size() !== 0) begin n_fail++; $display("FAIL ss_err_count[%0d] got=%0d exp=0", k, err_t.size()); end
      n_checks++; if (error_count !== 8'd0) begin n_fail++; $display("FAIL ss_errcnt[%0d] got=%0d exp=0", k, error_count); end
      if (rd_t.size() == 1 && wr_done_t.size() == 1) begin
        // One cycle to sample write idle, then MW cycles of conversion wait.
        n_checks++;
        if (rd_t[0] - wr_done_t[0] !== int'(MW) + 1) begin
          n_fail++; $display("FAIL ss_meas_wait[%0d] got=%0d exp=%0d", k, rd_t[0] - wr_done_t[0], MW + 1);
        end
      end
      if (valid_t.size() == 1 && rd_done_t.size() == 1) begin
        n_checks++;
        if (valid_t[0] !== rd_done_t[0] + 1) begin
          n_fail++; $display("FAIL ss_valid_time[%0d] got=%0d exp=%0d", k, valid_t[0], rd_done_t[0] + 1);
        end
      end
    end
  endtask

  task automatic test_period();
    bit ok;
    int r;
    int exp_t[$];
    mode = M_OK;
    clear_log();
    enable = 1'b1;
    do_reset();
    r = ncyc;
    repeat (649) @(negedge clk);
    #1 enable = 1'b0;
    wait_quiet(300, ok);
    for (int t = 1; t < 650; t += int'(PC)) exp_t.push_back(t);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL per_quiet busy never settled"); end
    n_checks++; if (wr_t.size() !== exp_t.size()) begin n_fail++; $display("FAIL per_starts got=%0d exp=%0d", wr_t.size(), exp_t.size()); end
    n_checks++; if (valid_t.size() !== exp_t.size()) begin n_fail++; $display("FAIL per_valids got=%0d exp=%0d", valid_t.size(), exp_t.size()); end
    for (int i = 0; i < exp_t.size() && i < wr_t.size(); i++) begin
      n_checks++;
      if (wr_t[i] - r !== exp_t[i]) begin
        n_fail++; $display("FAIL per_start_time[%0d] got=%0d exp=%0d", i, wr_t[i] - r, exp_t[i]);
      end
    end
  endtask

  task automatic test_crc_retry();
    bit ok;
    mode = M_CRC;
    clear_log();
    do_reset();
    pulse_single();
    wait_quiet(1000, ok);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL crc_quiet busy never settled"); end
    n_checks++; if (wr_t.size() !== int'(RM) + 1) begin n_fail++; $display("FAIL crc_writes got=%0d exp=%0d", wr_t.size(), RM + 1); end
    n_checks++; if (rd_t.size() !== int'(RM) + 1) begin n_fail++; $display("FAIL crc_reads got=%0d exp=%0d", rd_t.size(), RM + 1); end
    n_checks++; if (err_t.size() !== 1) begin n_fail++; $display("FAIL crc_error_pulses got=%0d exp=1", err_t.size()); end
    n_checks++; if (valid_t.size() !== 0) begin n_fail++; $display("FAIL crc_valid_pulses got=%0d exp=0", valid_t.size()); end
    n_checks++; if (error_count !== 8'(RM + 1)) begin n_fail++; $display("FAIL crc_errcnt got=%0d exp=%0d", error_count, RM + 1); end
    mode = M_OK;
  endtask

  task automatic test_timeout();
    bit ok;
    mode = M_STUCK;
    clear_log();
    do_reset();
    pulse_single();
    wait_quiet(1000, ok);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL to_quiet busy never settled"); end
    n_checks++; if (wr_t.size() !== int'(RM) + 1) begin n_fail++; $display("FAIL to_requests got=%0d exp=%0d", wr_t.size(), RM + 1); end
    n_checks++; if (rd_t.size() !== 0) begin n_fail++; $display("FAIL to_reads got=%0d exp=0", rd_t.size()); end
    n_checks++; if (req_len.size() !== int'(RM) + 1) begin n_fail++; $display("FAIL to_req_ends got=%0d exp=%0d", req_len.size(), RM + 1); end
    for (int i = 0; i < req_len.size(); i++) begin
      n_checks++;
      if (req_len[i] !== int'(XT)) begin n_fail++; $display("FAIL to_req_len[%0d] got=%0d exp=%0d", i, req_len[i], XT); end
    end
    for (int i = 0; i + 1 < wr_t.size(); i++) begin
      n_checks++;
      if (wr_t[i + 1] - wr_t[i] !== int'(XT) + 1) begin
        n_fail++; $display("FAIL to_retry_gap[%0d] got=%0d exp=%0d", i, wr_t[i + 1] - wr_t[i], XT + 1);
      end
    end
    n_checks++; if (err_t.size() !== 1) begin n_fail++; $display("FAIL to_error_pulses got=%0d exp=1", err_t.size()); end
    n_checks++; if (error_count !== 8'(RM + 1)) begin n_fail++; $display("FAIL to_errcnt got=%0d exp=%0d", error_count, RM + 1); end
    n_checks++; if (processor_ready !== 1'b0) begin n_fail++; $display("FAIL to_pr_after got=%b exp=0", processor_ready); end
    mode = M_OK;
  endtask

  task automatic test_back_to_back();
    bit ok;
    mode = M_OK;
    clear_log();
    pulse_single();
    for (int p = 0; p < 3; p++) begin
      repeat ($urandom_range(1, 4)) @(negedge clk);
      pulse_single();
    end
    wait_quiet(1000, ok);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL b2b_quiet busy never settled"); end
    n_checks++; if (wr_t.size() !== 2) begin n_fail++; $display("FAIL b2b_writes got=%0d exp=2", wr_t.size()); end
    n_checks++; if (rd_t.size() !== 2) begin n_fail++; $display("FAIL b2b_reads got=%0d exp=2", rd_t.size()); end
    n_checks++; if (valid_t.size() !== 2) begin n_fail++; $display("FAIL b2b_valids got=%0d exp=2", valid_t.size()); end
    if (valid_t.size() == 2 && wr_t.size() == 2) begin
      // DONE -> one IDLE cycle -> WR_REQ for the pending request.
      n_checks++;
      if (wr_t[1] !== valid_t[0] + 2) begin n_fail++; $display("FAIL b2b_restart got=%0d exp=%0d", wr_t[1], valid_t[0] + 2); end
    end
  endtask

  task automatic test_saturate();
    bit ok;
    int exp_ec;
    mode = M_CRC;
    clear_log();
    do_reset();
    for (int i = 0; i < 64; i++) begin
      pulse_single();
      wait_quiet(1000, ok);
      exp_ec = ((i + 1) * int'(RM + 1) > 255) ? 255 : (i + 1) * int'(RM + 1);
      n_checks++;
      if (!ok || error_count !== 8'(exp_ec)) begin
        n_fail++; $display("FAIL sat_errcnt[%0d] got=%0d exp=%0d settled=%0d", i, error_count, exp_ec, ok);
      end
    end
    n_checks++; if (err_t.size() !== 64) begin n_fail++; $display("FAIL sat_error_pulses got=%0d exp=64", err_t.size()); end
    mode = M_OK;
  endtask

  task automatic test_reset_mid();
    bit ok;
    bit found;
    mode = M_OK;
    clear_log();
    pulse_single();
    found = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk); #1;
      if (busy && !i2c_writes && !processor_ready) begin
        found = 1'b1;
        break;
      end
    end
    n_checks++; if (!found) begin n_fail++; $display("FAIL rm_reach_rd_wait not reached"); end
    #2 rst = 1'b1;
    #1;
    n_checks++; if (processor_ready !== 1'b0) begin n_fail++; $display("FAIL rm_pr got=%b exp=0", processor_ready); end
    n_checks++; if (i2c_writes !== 1'b1) begin n_fail++; $display("FAIL rm_writes got=%b exp=1", i2c_writes); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rm_busy got=%b exp=0", busy); end
    n_checks++; if (meas_valid !== 1'b0 || meas_error !== 1'b0) begin n_fail++; $display("FAIL rm_pulses got=%b%b exp=00", meas_valid, meas_error); end
    n_checks++; if (error_count !== 8'd0) begin n_fail++; $display("FAIL rm_errcnt got=%0d exp=0", error_count); end
    repeat (2) @(negedge clk);
    #1 rst = 1'b0;
    clear_log();
    pulse_single();
    wait_quiet(500, ok);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL rm_after_quiet busy never settled"); end
    n_checks++; if (valid_t.size() !== 1) begin n_fail++; $display("FAIL rm_after_valid got=%0d exp=1", valid_t.size()); end
    n_checks++; if (error_count !== 8'd0) begin n_fail++; $display("FAIL rm_after_errcnt got=%0d exp=0", error_count); end
  endtask

  initial begin
    test_reset();
    test_single_shot();
    test_period();
    test_crc_retry();
    test_timeout();
    test_back_to_back();
    test_saturate();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1);
  end

endmodule
